// File: rtl/mix_state_reader_if.sv
// Handshake bundle between the state-word source, the signature reader and its consumer.
// master drives words and signature ready; slave is the reader block.
interface mix_state_reader_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_last;
   logic         sig_valid;
   logic         sig_ready;
   logic [W-1:0] sig_data;
   logic [15:0]  sig_count;
   logic         err;

   modport slave (
      input  in_valid, in_data, in_last, sig_ready,
      output in_ready, sig_valid, sig_data, sig_count, err
   );

   modport master (
      output in_valid, in_data, in_last, sig_ready,
      input  in_ready, sig_valid, sig_data, sig_count, err
   );
endinterface

// File: rtl/mix_state_reader.sv
// Buffers one NWORDS-word frame, folds it into a W-bit signature over NWORDS cycles, then offers it.
// Optional completed-frame counter: define MIX_STATE_READER_CNT_EN, otherwise sig_count reads zero.
module mix_state_reader #(
   parameter int NWORDS = 8,
   parameter int W      = 32
) (
   input logic             clk,
   input logic             rst,
   mix_state_reader_if.slave bus
);
   localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      MIX     = 2'd1,
      OUT     = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [IW-1:0] rnd, rnd_nxt;
   logic [W-1:0]  acc, acc_nxt;
   logic          err_nxt;
   logic          wr_en;
   logic          in_ready_q;
   logic          sig_valid_q;
   logic          err_q;
   logic [W-1:0]  wbuf [NWORDS];

   logic [W-1:0]  mix_t;
   logic [W-1:0]  mix_x;
   logic [W-1:0]  mix_val;

   // One mixing round; all operands are W bits so every step wraps modulo 2^W.
   always_comb begin
      mix_t   = acc + wbuf[rnd];
      mix_x   = mix_t ^ (mix_t << 16);
      mix_val = (mix_x * W'(3)) + W'(5);
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      rnd_nxt   = rnd;
      acc_nxt   = acc;
      err_nxt   = 1'b0;
      wr_en     = 1'b0;
      case (state)
         COLLECT: begin
            if (bus.in_valid && in_ready_q) begin
               wr_en = 1'b1;
               if (idx == LAST) begin
                  // A full frame is processed even when in_last is missing; only flag it.
                  idx_nxt   = '0;
                  rnd_nxt   = '0;
                  acc_nxt   = '0;
                  state_nxt = MIX;
                  err_nxt   = ~bus.in_last;
               end else if (bus.in_last) begin
                  idx_nxt = '0;
                  err_nxt = 1'b1;
               end else begin
                  idx_nxt = idx + IW'(1);
               end
            end
         end
         MIX: begin
            acc_nxt = mix_val;
            if (rnd == LAST) begin
               rnd_nxt   = '0;
               state_nxt = OUT;
            end else begin
               rnd_nxt = rnd + IW'(1);
            end
         end
         OUT: begin
            if (sig_valid_q && bus.sig_ready) begin
               state_nxt = COLLECT;
            end
         end
         default: begin
            state_nxt = COLLECT;
            idx_nxt   = '0;
            rnd_nxt   = '0;
            acc_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= COLLECT;
         idx         <= '0;
         rnd         <= '0;
         acc         <= '0;
         in_ready_q  <= 1'b1;
         sig_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         rnd         <= rnd_nxt;
         acc         <= acc_nxt;
         in_ready_q  <= (state_nxt == COLLECT);
         sig_valid_q <= (state_nxt == OUT);
         err_q       <= err_nxt;
      end
   end

   // Frame storage carries no reset; every slot is rewritten before it is read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         wbuf[idx] <= bus.in_data;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.sig_valid = sig_valid_q;
   assign bus.sig_data  = acc;
   assign bus.err       = err_q;

`ifdef MIX_STATE_READER_CNT_EN
   logic        cnt_inc;
   logic [15:0] cnt_q;

   assign cnt_inc = sig_valid_q && bus.sig_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 16'h0000;
      end else if (cnt_inc) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign bus.sig_count = cnt_q;
`else
   assign bus.sig_count = 16'h0000;
`endif

endmodule

// File: doc/mix_state_reader.md
# mix_state_reader

Consumer end of the mixed-state register bank. Accepts one frame of NWORDS state words, one word per valid/ready handshake, buffers it, folds it into a W-bit signature over NWORDS mixing cycles, and then presents the signature on an output handshake. Used beside the state-mixing stimulus so a bench can compare compact signatures rather than full register dumps.

## Interface
- NWORDS, 8, words per frame (2..256)
- W, 32, word and signature width
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  word available
- in_ready  out  1  block accepts a word this cycle
- in_data  in  W  state word
- in_last  in  1  marks the final word of a frame
- sig_valid  out  1  signature available
- sig_ready  in  1  downstream takes the signature
- sig_data  out  W  frame signature
- sig_count  out  16  completed-frame counter
- err  out  1  one-cycle framing-error pulse

## Operation
- States: COLLECT, MIX, OUT.
- COLLECT: in_ready=1. A word is accepted when in_valid&&in_ready and stored at buf[idx], then idx increments.
- The frame closes when the accepted word has idx==NWORDS-1. idx then clears, acc clears to 0, rnd clears to 0, and the state moves to MIX.
- Early in_last (in_last=1 with idx<NWORDS-1):
  - the partial frame is discarded and idx returns to 0;
  - the state stays COLLECT;
  - err pulses.
- Missing in_last (in_last=0 on word NWORDS-1):
  - the frame is still processed normally;
  - err pulses.
- MIX: in_ready=0. One round per cycle, for rnd=0..NWORDS-1:
  - t = acc + buf[rnd]
  - acc = ((t ^ (t << 16)) * 3) + 5
  - All arithmetic is modulo 2^W; the shift is a logical left shift truncated to W bits.
- After round NWORDS-1 the state moves to OUT.
- OUT: sig_valid=1, sig_data=acc, in_ready=0.
  - On sig_valid&&sig_ready: sig_count increments (wraps 0xFFFF->0x0000) and the state returns to COLLECT.
  - sig_data is held stable while sig_valid=1 and sig_ready=0.
- rst (any time, including mid-frame or mid-MIX):
  - state=COLLECT, idx=0, rnd=0, acc=0;
  - outputs: in_ready=1, sig_valid=0, sig_data=0, sig_count=0, err=0;
  - buffer contents are don't-care.

## Timing
- in_ready, sig_valid and err are registered, with no combinational path from inputs to outputs.
- Last word accepted at edge k:
  - in_ready=0 from k;
  - rounds execute at edges k+1..k+NWORDS;
  - sig_valid=1 from edge k+NWORDS.
  - Latency from last accept to sig_valid is NWORDS cycles.
- Signature handshake at edge m: sig_valid=0 and in_ready=1 from m. A new word can be accepted at edge m+1.
- Back-to-back frames: one frame every NWORDS + NWORDS + 1 cycles minimum (collect, mix, one-cycle output).
- err is high for exactly the one cycle after the offending accept edge. It coexists with the MIX transition for the missing-in_last case.
- in_valid during MIX or OUT is ignored; data is not consumed.

## Configuration
- MIX_STATE_READER_CNT_EN:
  - Defined: sig_count is implemented as described.
  - Undefined: the counter register is omitted and sig_count is tied to 16'h0000. All other behaviour is identical.

## Test plan
- NWORDS=2, frame {0,0} with in_last on word 1 -> sig_data=0x000F0014, err never asserted, sig_count=1, sig_valid exactly 2 cycles after the last accept.
- NWORDS=2, frame {1,2} -> sig_data=0x001B0023. Hold sig_ready=0 for 5 cycles -> sig_data stable, in_ready=0 throughout, and after the handshake in_ready=1 on the next cycle.
- NWORDS=2, word 0 = 7 with in_last=1, then frame {1,2} -> one err pulse after the first accept, and the next signature is 0x001B0023 (the partial frame was discarded).
- NWORDS=2, frame {0,0} with in_last=0 on both words -> err pulse one cycle after the second accept, sig_data=0x000F0014.
- Assert rst during MIX round 0, then send frame {1,2} -> after reset sig_valid=0, sig_count=0, in_ready=1; the following signature is 0x001B0023 and sig_count=1.
- Default NWORDS=8, 65537 frames with the macro defined -> sig_count=0x0001 (wrap). Without the macro -> sig_count=0 throughout.
